// File: rtl/io_core_pkg.sv
// io_core_pkg: shared widths, register offsets and the probe payload layout
// for the io_core debug-bus probe core.
package io_core_pkg;

    // Debug bus width
    localparam int unsigned BUS_W = 16;

    // Input probe widths
    localparam int unsigned PICARD_W  = 1;
    localparam int unsigned DATA_W    = 7;
    localparam int unsigned LAFORGE_W = 10;
    localparam int unsigned TROI_W    = 1;
    localparam int unsigned PROBE_IN_W = PICARD_W + DATA_W + LAFORGE_W + TROI_W;

    // Output probe widths
    localparam int unsigned KIRK_W   = 1;
    localparam int unsigned SPOCK_W  = 5;
    localparam int unsigned UHURA_W  = 3;
    localparam int unsigned CHEKOV_W = 1;

    // Register offsets relative to BASE_ADDR
    localparam logic [BUS_W-1:0] STROBE_OFS  = BUS_W'(0);
    localparam logic [BUS_W-1:0] PICARD_OFS  = BUS_W'(1);
    localparam logic [BUS_W-1:0] DATA_OFS    = BUS_W'(2);
    localparam logic [BUS_W-1:0] LAFORGE_OFS = BUS_W'(3);
    localparam logic [BUS_W-1:0] TROI_OFS    = BUS_W'(4);
    localparam logic [BUS_W-1:0] KIRK_OFS    = BUS_W'(5);
    localparam logic [BUS_W-1:0] SPOCK_OFS   = BUS_W'(6);
    localparam logic [BUS_W-1:0] UHURA_OFS   = BUS_W'(7);
    localparam logic [BUS_W-1:0] CHEKOV_OFS  = BUS_W'(8);
    localparam logic [BUS_W-1:0] LAST_OFS    = BUS_W'(8);

    // All input probes as one bundle, so they can be synchronized and captured together
    typedef struct packed {
        logic [PICARD_W-1:0]  picard;
        logic [DATA_W-1:0]    data;
        logic [LAFORGE_W-1:0] laforge;
        logic [TROI_W-1:0]    troi;
    } probe_in_t;

    // True when addr lies in base..base+LAST_OFS; the lower-bound test keeps
    // addresses below base from wrapping into the window
    function automatic logic addr_in_window(input logic [BUS_W-1:0] addr,
                                            input logic [BUS_W-1:0] base);
        logic [BUS_W-1:0] ofs;
        ofs = addr - base;
        return (addr >= base) && (ofs <= LAST_OFS);
    endfunction

endpackage : io_core_pkg

// File: rtl/io_core_sync.sv
// io_core_sync: parameterized-width 2-flop synchronizer, reset to 0.
// Only instantiated when IO_CORE_SYNC_INPUTS_EN is defined.
module io_core_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops to resolve metastability on asynchronous probe pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : io_core_sync

// File: rtl/io_core.sv
// io_core: register-mapped probe core on the daisy-chained 16-bit debug bus.
// Input probes are captured and output probes updated together on a rising
// edge of the strobe register. Every bus transaction is forwarded with one
// register stage of latency.
// Optional build macro: IO_CORE_SYNC_INPUTS_EN adds a 2-flop synchronizer
// on the input probes ahead of the input buffers.
module io_core
    import io_core_pkg::*;
#(
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned SAMPLE_DEPTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [PICARD_W-1:0]  picard,
    input  logic [DATA_W-1:0]    data,
    input  logic [LAFORGE_W-1:0] laforge,
    input  logic [TROI_W-1:0]    troi,

    output logic [KIRK_W-1:0]    kirk,
    output logic [SPOCK_W-1:0]   spock,
    output logic [UHURA_W-1:0]   uhura,
    output logic [CHEKOV_W-1:0]  chekov,

    input  logic [BUS_W-1:0]     addr_i,
    input  logic [BUS_W-1:0]     wdata_i,
    input  logic [BUS_W-1:0]     rdata_i,
    input  logic                 rw_i,
    input  logic                 valid_i,

    output logic [BUS_W-1:0]     addr_o,
    output logic [BUS_W-1:0]     wdata_o,
    output logic [BUS_W-1:0]     rdata_o,
    output logic                 rw_o,
    output logic                 valid_o
);

    // SAMPLE_DEPTH only exists for parameter-list compatibility with sibling cores
    if (SAMPLE_DEPTH == 0) begin : g_bad_depth
        $error("io_core: SAMPLE_DEPTH must be non-zero");
    end

    localparam logic [BUS_W-1:0] BASE = BUS_W'(BASE_ADDR);

    // Bus decode
    logic [BUS_W-1:0] w_ofs;
    logic             w_hit;
    logic             w_wr;
    logic             w_rd;
    logic [BUS_W-1:0] w_rd_val;

    // Strobe and probe state
    logic             r_strobe;
    logic             r_strobe_q;
    logic             w_strobe_rise;

    probe_in_t        w_pins;
    probe_in_t        w_pins_s;
    probe_in_t        r_in;

    logic [KIRK_W-1:0]   r_buf_kirk;
    logic [SPOCK_W-1:0]  r_buf_spock;
    logic [UHURA_W-1:0]  r_buf_uhura;
    logic [CHEKOV_W-1:0] r_buf_chekov;

    logic [KIRK_W-1:0]   r_kirk;
    logic [SPOCK_W-1:0]  r_spock;
    logic [UHURA_W-1:0]  r_uhura;
    logic [CHEKOV_W-1:0] r_chekov;

    // Bus pipeline registers
    logic [BUS_W-1:0] r_addr_o;
    logic [BUS_W-1:0] r_wdata_o;
    logic [BUS_W-1:0] r_rdata_o;
    logic             r_rw_o;
    logic             r_valid_o;

    assign w_ofs = addr_i - BASE;
    assign w_hit = valid_i && addr_in_window(addr_i, BASE);
    assign w_wr  = w_hit && rw_i;
    assign w_rd  = w_hit && !rw_i;

    assign w_strobe_rise = r_strobe && !r_strobe_q;

    assign w_pins = {picard, data, laforge, troi};

`ifdef IO_CORE_SYNC_INPUTS_EN
    io_core_sync #(
        .W (PROBE_IN_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (w_pins),
        .o_q (w_pins_s)
    );
`else
    assign w_pins_s = w_pins;
`endif

    // Read mux: zero-extended register value for the addressed offset
    always_comb begin
        w_rd_val = '0;
        case (w_ofs)
            STROBE_OFS:  w_rd_val = BUS_W'(r_strobe);
            PICARD_OFS:  w_rd_val = BUS_W'(r_in.picard);
            DATA_OFS:    w_rd_val = BUS_W'(r_in.data);
            LAFORGE_OFS: w_rd_val = BUS_W'(r_in.laforge);
            TROI_OFS:    w_rd_val = BUS_W'(r_in.troi);
            KIRK_OFS:    w_rd_val = BUS_W'(r_buf_kirk);
            SPOCK_OFS:   w_rd_val = BUS_W'(r_buf_spock);
            UHURA_OFS:   w_rd_val = BUS_W'(r_buf_uhura);
            CHEKOV_OFS:  w_rd_val = BUS_W'(r_buf_chekov);
            default:     w_rd_val = '0;
        endcase
    end

    // Bus pass-through stage; reads that hit this core replace the upstream rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_o  <= '0;
            r_wdata_o <= '0;
            r_rdata_o <= '0;
            r_rw_o    <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            r_addr_o  <= addr_i;
            r_wdata_o <= wdata_i;
            r_rw_o    <= rw_i;
            r_valid_o <= valid_i;
            r_rdata_o <= w_rd ? w_rd_val : rdata_i;
        end
    end

    // Writable registers: strobe and output buffers; RO offsets fall through untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe     <= 1'b0;
            r_buf_kirk   <= '0;
            r_buf_spock  <= '0;
            r_buf_uhura  <= '0;
            r_buf_chekov <= '0;
        end else if (w_wr) begin
            case (w_ofs)
                STROBE_OFS: r_strobe     <= wdata_i[0];
                KIRK_OFS:   r_buf_kirk   <= wdata_i[KIRK_W-1:0];
                SPOCK_OFS:  r_buf_spock  <= wdata_i[SPOCK_W-1:0];
                UHURA_OFS:  r_buf_uhura  <= wdata_i[UHURA_W-1:0];
                CHEKOV_OFS: r_buf_chekov <= wdata_i[CHEKOV_W-1:0];
                default:    ;
            endcase
        end
    end

    // Atomic probe transfer on a 0->1 of the registered strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_q <= 1'b0;
            r_in       <= '0;
            r_kirk     <= '0;
            r_spock    <= '0;
            r_uhura    <= '0;
            r_chekov   <= '0;
        end else begin
            r_strobe_q <= r_strobe;
            if (w_strobe_rise) begin
                r_in     <= w_pins_s;
                r_kirk   <= r_buf_kirk;
                r_spock  <= r_buf_spock;
                r_uhura  <= r_buf_uhura;
                r_chekov <= r_buf_chekov;
            end
        end
    end

    assign kirk    = r_kirk;
    assign spock   = r_spock;
    assign uhura   = r_uhura;
    assign chekov  = r_chekov;

    assign addr_o  = r_addr_o;
    assign wdata_o = r_wdata_o;
    assign rdata_o = r_rdata_o;
    assign rw_o    = r_rw_o;
    assign valid_o = r_valid_o;

endmodule : io_core

// File: tb/tb_io_core.sv
// tb_io_core: scoreboard bench for io_core. Every driven bus transaction
// pushes its expected forwarded beat; a monitor pops and compares when
// valid_o appears. A small register model supplies expected read data.
module tb_io_core;
    import io_core_pkg::*;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  picard;
    logic [6:0]  data;
    logic [9:0]  laforge;
    logic [0:0]  troi;
    logic [0:0]  kirk;
    logic [4:0]  spock;
    logic [2:0]  uhura;
    logic [0:0]  chekov;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;

    always #5 clk = ~clk;

    io_core #(
        .BASE_ADDR    (32'h0040),
        .SAMPLE_DEPTH (128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .picard  (picard),
        .data    (data),
        .laforge (laforge),
        .troi    (troi),
        .kirk    (kirk),
        .spock   (spock),
        .uhura   (uhura),
        .chekov  (chekov),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_i (rdata_i),
        .rw_i    (rw_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rdata_o (rdata_o),
        .rw_o    (rw_o),
        .valid_o (valid_o)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        rw;
    } txn_t;

    txn_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Register model
    logic       m_strobe;
    logic [0:0] m_in_picard;
    logic [6:0] m_in_data;
    logic [9:0] m_in_laforge;
    logic [0:0] m_in_troi;
    logic [0:0] m_buf_kirk, m_pin_kirk;
    logic [4:0] m_buf_spock, m_pin_spock;
    logic [2:0] m_buf_uhura, m_pin_uhura;
    logic [0:0] m_buf_chekov, m_pin_chekov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_strobe = 1'b0;
        m_in_picard = '0; m_in_data = '0; m_in_laforge = '0; m_in_troi = '0;
        m_buf_kirk = '0; m_buf_spock = '0; m_buf_uhura = '0; m_buf_chekov = '0;
        m_pin_kirk = '0; m_pin_spock = '0; m_pin_uhura = '0; m_pin_chekov = '0;
    endtask

    function automatic logic [15:0] model_val(input logic [15:0] ofs);
        case (ofs)
            16'd0:   return {15'd0, m_strobe};
            16'd1:   return {15'd0, m_in_picard};
            16'd2:   return {9'd0, m_in_data};
            16'd3:   return {6'd0, m_in_laforge};
            16'd4:   return {15'd0, m_in_troi};
            16'd5:   return {15'd0, m_buf_kirk};
            16'd6:   return {11'd0, m_buf_spock};
            16'd7:   return {13'd0, m_buf_uhura};
            16'd8:   return {15'd0, m_buf_chekov};
            default: return 16'd0;
        endcase
    endfunction

    // One bus beat followed by an idle cycle; expected output pushed at drive time
    task automatic bus_op(input logic [15:0] a, input logic rw, input logic [15:0] wd,
                          input logic [15:0] rd_in, input logic [15:0] exp_rd);
        txn_t t;
        @(posedge clk); #1;
        addr_i = a; rw_i = rw; wdata_i = wd; rdata_i = rd_in; valid_i = 1'b1;
        t.addr = a; t.wdata = wd; t.rdata = exp_rd; t.rw = rw;
        sb_q.push_back(t);
        @(posedge clk); #1;
        valid_i = 1'b0;
        addr_i  = 16'($urandom);
        rdata_i = 16'($urandom);
    endtask

    task automatic rd(input logic [15:0] a);
        logic [15:0] rdi, exp;
        rdi = 16'($urandom);
        if (a >= BASE && a <= BASE + 16'd8) exp = model_val(a - BASE);
        else                                exp = rdi;
        bus_op(a, 1'b0, 16'($urandom), rdi, exp);
    endtask

    task automatic wr_addr(input logic [15:0] a, input logic [15:0] v);
        logic [15:0] rdi;
        rdi = 16'($urandom);
        bus_op(a, 1'b1, v, rdi, rdi);
        if (a >= BASE && a <= BASE + 16'd8) begin
            case (a - BASE)
                16'd0: begin
                    if (v[0] && !m_strobe) begin
                        m_in_picard = picard; m_in_data = data;
                        m_in_laforge = laforge; m_in_troi = troi;
                        m_pin_kirk = m_buf_kirk; m_pin_spock = m_buf_spock;
                        m_pin_uhura = m_buf_uhura; m_pin_chekov = m_buf_chekov;
                    end
                    m_strobe = v[0];
                end
                16'd5: m_buf_kirk   = v[0];
                16'd6: m_buf_spock  = v[4:0];
                16'd7: m_buf_uhura  = v[2:0];
                16'd8: m_buf_chekov = v[0];
                default: ;
            endcase
        end
    endtask

    task automatic wr(input int ofs, input logic [15:0] v);
        wr_addr(BASE + 16'(ofs), v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pins(input string tag);
        check({tag, "_kirk"},   32'(kirk),   32'(m_pin_kirk));
        check({tag, "_spock"},  32'(spock),  32'(m_pin_spock));
        check({tag, "_uhura"},  32'(uhura),  32'(m_pin_uhura));
        check({tag, "_chekov"}, 32'(chekov), 32'(m_pin_chekov));
    endtask

    // Monitor: pop and compare each forwarded beat
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid_o", 32'(valid_o), 32'd0);
            end else begin
                txn_t t;
                t = sb_q.pop_front();
                check("addr_o",  32'(addr_o),  32'(t.addr));
                check("wdata_o", 32'(wdata_o), 32'(t.wdata));
                check("rw_o",    32'(rw_o),    32'(t.rw));
                check("rdata_o", 32'(rdata_o), 32'(t.rdata));
            end
        end
    end

    // Run-time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        picard = '0; data = '0; laforge = '0; troi = '0;
        addr_i = '0; wdata_i = '0; rdata_i = '0; rw_i = 1'b0; valid_i = 1'b0;
        model_reset();
        idle(3);

        // Reset state
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_rdata_o", 32'(rdata_o), 32'd0);
        check("rst_addr_o",  32'(addr_o),  32'd0);
        check_pins("rst");
        rst = 1'b0;
        idle(2);

        // Strobe reads back 0 after reset
        rd(BASE);

        // RO write ignored; input buffers all 0 before any strobe
        wr(2, 16'h0055);
        for (int i = 1; i <= 4; i++) rd(BASE + 16'(i));

        // Strobe captures input probes
        picard = 1'b1; data = 7'h5A; laforge = 10'h3C3; troi = 1'b1;
        wr(0, 16'h0000);
        wr(0, 16'h0001);
        idle(2);
        for (int i = 0; i <= 4; i++) rd(BASE + 16'(i));

        // Output buffers: pins do not move until the strobe edge; writes truncate
        wr(0, 16'h0000);
        wr(6, 16'h001F);
        wr(7, 16'hFFFF);
        idle(2);
        check_pins("prestrobe");
        rd(BASE + 16'd6);
        rd(BASE + 16'd7);
        wr(0, 16'h0001);
        idle(2);
        check_pins("strobe1");

        // Holding strobe at 1 gives no further transfer
        wr(5, 16'h0001);
        wr(8, 16'hFFFF);
        data = 7'h21; laforge = 10'h155; picard = 1'b0;
        wr(0, 16'h0001);
        idle(2);
        check_pins("hold");
        rd(BASE + 16'd2);
        rd(BASE + 16'd8);
        wr(0, 16'h0000);
        wr(0, 16'h0001);
        idle(2);
        check_pins("strobe2");
        for (int i = 1; i <= 3; i++) rd(BASE + 16'(i));

        // Out-of-window addresses pass through untouched
        rd(BASE + 16'd9);
        rd(BASE - 16'd1);
        rd(16'hFFFF);
        wr_addr(BASE + 16'd9, 16'h0000);
        wr_addr(BASE - 16'd1, 16'h0000);
        wr_addr(BASE + 16'h1005, 16'h0000);
        rd(BASE + 16'd5);
        rd(BASE + 16'd8);
        rd(BASE);

        // Reset in the middle of a transaction with probe outputs set
        @(posedge clk); #1;
        addr_i = BASE + 16'd5; rw_i = 1'b0; valid_i = 1'b1; rdata_i = 16'h1234;
        @(posedge clk); #1;
        check("pre_rst_valid_o", 32'(valid_o), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check_pins("midrst");
        valid_i = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);
        rd(BASE);
        rd(BASE + 16'd6);
        rd(BASE + 16'd2);

        idle(4);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_core
